// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU systolic-array job scheduler.
package mpu_pkg;

   // Systolic array edge length (int8 operands).
   localparam int unsigned SA_DIM      = 8;
   // Default watchdog limit in RUN cycles.
   localparam int unsigned TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      StIdle,
      StGrant,
      StClear,
      StRun,
      StDone,
      StAbort
   } state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority pick: first requester at or after i_ptr, wrapping modulo NREQ.
module rr_arb #(
   parameter int unsigned  NREQ = 2,
   localparam int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic            o_valid,
   output logic [IW-1:0]   o_idx
);

   // Scan from the farthest offset back to ptr so the nearest requester wins.
   always_comb begin
      int          w_pos;
      logic [IW-1:0] w_sel;
      o_valid = 1'b0;
      o_idx   = '0;
      w_pos   = 0;
      w_sel   = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         w_pos = (int'(i_ptr) + k) % int'(NREQ);
         w_sel = IW'(w_pos);
         if (i_req[w_sel]) begin
            o_valid = 1'b1;
            o_idx   = w_sel;
         end
      end
   end

endmodule

// File: rtl/mpu_sched.sv
// Job scheduler that time-shares one systolic array between NREQ requesters.
module mpu_sched
   import mpu_pkg::*;
#(
   parameter int unsigned  NREQ    = 2,
   parameter int unsigned  TIMEOUT = TIMEOUT_DEF,
   localparam int unsigned IW      = $clog2(NREQ)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [NREQ-1:0] i_req,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_gnt_idx,
   output logic [NREQ-1:0] o_done,
   output logic            o_sa_rst,
   output logic            o_sa_control,
   input  logic            i_sa_busy,
   output logic            o_err,
   output logic [7:0]      o_last_cycles
);

   state_e          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_done;
   logic            r_sa_rst;
   logic            r_sa_ctrl;
   logic            r_err;
   logic [7:0]      r_last;
   logic [7:0]      r_run_cnt;

   logic            w_arb_valid;
   logic [IW-1:0]   w_arb_idx;
   logic [NREQ-1:0] w_arb_oh;
   logic [NREQ-1:0] w_own_oh;
   logic [IW-1:0]   w_ptr_nxt;
   logic            w_own_req;
   logic            w_job;
   logic            w_drop;
   logic            w_timeout;

   rr_arb #(
      .NREQ(NREQ)
   ) u_arb (
      .i_req  (i_req),
      .i_ptr  (r_ptr),
      .o_valid(w_arb_valid),
      .o_idx  (w_arb_idx)
   );

   assign w_arb_oh  = NREQ'(1) << w_arb_idx;
   assign w_own_oh  = NREQ'(1) << r_owner;
   assign w_ptr_nxt = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
   assign w_own_req = i_req[r_owner];
   assign w_job     = (r_state == StGrant) || (r_state == StClear) || (r_state == StRun);
   assign w_drop    = w_job && !w_own_req;
   // TIMEOUT >= 32, so the busy-ignore window never overlaps the watchdog limit.
   assign w_timeout = (r_state == StRun) && w_own_req && i_sa_busy &&
                      (r_run_cnt >= 8'(TIMEOUT));

   // Scheduler FSM; every output is registered together with the state it belongs to.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_gnt     <= '0;
         r_done    <= '0;
         r_sa_rst  <= 1'b0;
         r_sa_ctrl <= 1'b0;
         r_err     <= 1'b0;
         r_last    <= '0;
         r_run_cnt <= '0;
      end else begin
         r_done <= '0;
         if (w_drop || w_timeout) begin
            // Abandon the job: hold the array in reset and release the grant.
            r_gnt     <= '0;
            r_sa_rst  <= 1'b0;
            r_sa_ctrl <= 1'b0;
            r_ptr     <= w_ptr_nxt;
            r_state   <= StAbort;
            if (w_timeout) r_err <= 1'b1;
         end else begin
            case (r_state)
               StIdle: begin
                  r_gnt     <= '0;
                  r_sa_rst  <= 1'b1;
                  r_sa_ctrl <= 1'b0;
                  if (w_arb_valid) begin
                     r_owner <= w_arb_idx;
                     r_gnt   <= w_arb_oh;
                     r_state <= StGrant;
                  end
               end
               StGrant: begin
                  r_sa_rst <= 1'b0;
                  r_state  <= StClear;
               end
               StClear: begin
                  r_sa_rst  <= 1'b1;
                  r_sa_ctrl <= 1'b1;
                  r_run_cnt <= 8'd1;
                  r_state   <= StRun;
               end
               StRun: begin
                  // Busy is not trusted during the first two RUN cycles (stale low).
                  if ((r_run_cnt > 8'd2) && !i_sa_busy) begin
                     r_sa_ctrl <= 1'b0;
                     r_done    <= w_own_oh;
                     r_last    <= r_run_cnt;
                     r_ptr     <= w_ptr_nxt;
                     r_state   <= StDone;
                  end else begin
                     r_run_cnt <= r_run_cnt + 8'd1;
                  end
               end
               StDone: begin
                  r_gnt   <= '0;
                  r_state <= StIdle;
               end
               StAbort: begin
                  r_sa_rst <= 1'b1;
                  r_state  <= StIdle;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_gnt         = r_gnt;
   assign o_gnt_idx     = r_owner;
   assign o_done        = r_done;
   assign o_sa_rst      = r_sa_rst;
   assign o_sa_control  = r_sa_ctrl;
   assign o_err         = r_err;
   assign o_last_cycles = r_last;

endmodule

// File: tb/tb_mpu_sched.sv
// Directed bench for mpu_sched with a cycle-counting array busy model.
module tb_mpu_sched;

   typedef struct {
      logic [1:0] req;
      int         len;
      bit         hang;
      int         owner;
      bit         exp_done;
      int         runs;
      int         last;
      bit         err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = '0;
   logic [1:0] gnt;
   logic       gnt_idx;
   logic [1:0] done;
   logic       sa_rst;
   logic       sa_ctrl;
   logic       sa_busy;
   logic       err;
   logic [7:0] last_cycles;

   int   busy_len = 0;
   logic hang     = 1'b0;
   int   m_cnt    = 0;
   int   n_vec    = 0;
   int   n_bad    = 0;
   vec_t vt[14];

   always #5 clk = ~clk;

   mpu_sched #(
      .NREQ   (2),
      .TIMEOUT(64)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req        (req),
      .o_gnt        (gnt),
      .o_gnt_idx    (gnt_idx),
      .o_done       (done),
      .o_sa_rst     (sa_rst),
      .o_sa_control (sa_ctrl),
      .i_sa_busy    (sa_busy),
      .o_err        (err),
      .o_last_cycles(last_cycles)
   );

   // Array model: busy stays high until the len-th cycle with control asserted.
   always @(posedge clk) m_cnt <= sa_ctrl ? m_cnt + 1 : 0;
   assign sa_busy = hang | ((m_cnt + 1) < busy_len);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one job and follow it to its DONE or ABORT cycle.
   task automatic run_job(input vec_t v, input bit chk_gap, input string name);
      int runs = 0, clears = 0, first_g = 0;
      bit seen_g = 0, fin = 0, got_done = 0;
      req      = v.req;
      busy_len = v.len;
      hang     = v.hang;
      for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
         step();
         if (!seen_g && gnt != 2'b00) begin
            seen_g  = 1;
            first_g = cyc;
            check({name, " gnt_idx"}, 32'(gnt_idx), v.owner);
            check({name, " gnt"}, 32'(gnt), 1 << v.owner);
         end
         if (gnt != 2'b00 && !sa_rst) clears++;
         if (sa_ctrl) runs++;
         if (done != 2'b00) begin
            fin      = 1;
            got_done = 1;
            check({name, " done vec"}, 32'(done), 1 << v.owner);
            check({name, " gnt at done"}, 32'(gnt), 1 << v.owner);
         end else if (seen_g && gnt == 2'b00 && !sa_rst) begin
            fin = 1;
         end
      end
      check({name, " finished"}, 32'(fin), 1);
      if (chk_gap) check({name, " gap"}, first_g, 2);
      check({name, " clear cycles"}, clears, 1);
      check({name, " done seen"}, 32'(got_done), 32'(v.exp_done));
      check({name, " run cycles"}, runs, v.runs);
      check({name, " last_cycles"}, 32'(last_cycles), v.last);
      check({name, " err"}, 32'(err), 32'(v.err));
   endtask

   task automatic chk_reset_outs(input string name);
      check({name, " gnt"}, 32'(gnt), 0);
      check({name, " gnt_idx"}, 32'(gnt_idx), 0);
      check({name, " done"}, 32'(done), 0);
      check({name, " sa_ctrl"}, 32'(sa_ctrl), 0);
      check({name, " sa_rst"}, 32'(sa_rst), 0);
      check({name, " err"}, 32'(err), 0);
      check({name, " last"}, 32'(last_cycles), 0);
   endtask

   initial begin
      int runs;
      bit fin;
      vec_t vc;
      //           req    len hang own done runs last err
      vt[0]  = '{2'b11, 17, 0, 1, 1, 17, 17, 0};
      vt[1]  = '{2'b11,  5, 0, 0, 1,  5,  5, 0};
      vt[2]  = '{2'b11,  9, 0, 1, 1,  9,  9, 0};
      vt[3]  = '{2'b11,  1, 0, 0, 1,  3,  3, 0};
      vt[4]  = '{2'b11,  3, 0, 1, 1,  3,  3, 0};
      vt[5]  = '{2'b11,  2, 0, 0, 1,  3,  3, 0};
      vt[6]  = '{2'b11, 12, 0, 1, 1, 12, 12, 0};
      vt[7]  = '{2'b11,  8, 0, 0, 1,  8,  8, 0};
      vt[8]  = '{2'b10, 20, 0, 1, 1, 20, 20, 0};
      vt[9]  = '{2'b01,  4, 0, 0, 1,  4,  4, 0};
      vt[10] = '{2'b01,  0, 1, 0, 0, 64,  4, 1};
      vt[11] = '{2'b11,  6, 0, 1, 1,  6,  6, 1};
      vt[12] = '{2'b01, 64, 0, 0, 1, 64, 64, 1};
      vt[13] = '{2'b10, 65, 0, 1, 0, 64, 64, 1};

      // Reset state, then the first post-reset edge releases the array reset.
      repeat (3) step();
      chk_reset_outs("reset");
      rst = 1'b0;
      step();
      check("post-reset sa_rst", 32'(sa_rst), 1);
      check("post-reset gnt", 32'(gnt), 0);

      // Single job, phase by phase: GRANT, CLEAR, RUN for 17 cycles, DONE.
      req      = 2'b01;
      busy_len = 17;
      step();
      check("A grant gnt", 32'(gnt), 1);
      check("A grant ctrl", 32'(sa_ctrl), 0);
      check("A grant sa_rst", 32'(sa_rst), 1);
      step();
      check("A clear sa_rst", 32'(sa_rst), 0);
      check("A clear gnt", 32'(gnt), 1);
      step();
      check("A run ctrl", 32'(sa_ctrl), 1);
      check("A run sa_rst", 32'(sa_rst), 1);
      runs = 1;
      fin  = 0;
      for (int c = 0; c < 100 && !fin; c++) begin
         step();
         if (sa_ctrl) runs++;
         if (done != 2'b00) fin = 1;
      end
      check("A finished", 32'(fin), 1);
      check("A done", 32'(done), 1);
      check("A runs", runs, 17);
      check("A last", 32'(last_cycles), 17);

      // Owner withdraws in RUN cycle 5: abort, no done, err untouched.
      busy_len = 100;
      fin      = 0;
      for (int c = 0; c < 10 && !fin; c++) begin
         step();
         if (sa_ctrl) fin = 1;
      end
      check("B reached run", 32'(fin), 1);
      repeat (4) step();
      check("B still run", 32'(sa_ctrl), 1);
      req = 2'b00;
      step();
      check("B abort gnt", 32'(gnt), 0);
      check("B abort sa_rst", 32'(sa_rst), 0);
      check("B abort ctrl", 32'(sa_ctrl), 0);
      check("B abort done", 32'(done), 0);
      check("B abort err", 32'(err), 0);

      // Table: alternation, busy-ignore window, watchdog edges, pointer advance.
      for (int i = 0; i < 14; i++) run_job(vt[i], 1'b1, $sformatf("v%0d", i));

      // Reset mid-RUN drops the job; a fresh job then completes normally.
      req      = 2'b01;
      busy_len = 30;
      hang     = 1'b0;
      fin      = 0;
      for (int c = 0; c < 10 && !fin; c++) begin
         step();
         if (sa_ctrl) fin = 1;
      end
      check("C reached run", 32'(fin), 1);
      repeat (3) step();
      rst = 1'b1;
      step();
      chk_reset_outs("C reset");
      rst = 1'b0;
      step();
      check("C regrant sa_rst", 32'(sa_rst), 1);
      check("C regrant gnt", 32'(gnt), 1);
      vc = '{2'b01, 30, 0, 0, 1, 30, 30, 0};
      run_job(vc, 1'b0, "C job");

      req = 2'b00;
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
